// File: rtl/fir_prog.sv
// fir_prog -- programmable unsigned FIR filter, two-stage pipeline.
//
// Ports:
//   clk, rst              clock (rising edge) and async active-high reset
//   in_valid, in          sample strobe and sample; accepted when clear=0
//   clear                 synchronous flush of delay line and in-flight samples
//   coef_we/addr/data     coefficient write port (addr >= TAPS ignored)
//   out_valid, out, sat   one-cycle result pulse, filtered value, clamp flag
//
// Timing: accept edge shifts the delay line, the next edge registers the
// TAPS products, the edge after that registers the saturated sum.

// Per-tap product register.
module fir_prog_tap #(
    parameter int DW = 8,
    parameter int CW = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DW-1:0]    x,
    input  logic [CW-1:0]    c,
    output logic [DW+CW-1:0] p
);
    always_ff @(posedge clk or posedge rst) begin
        if (rst)     p <= '0;
        else if (en) p <= (DW+CW)'(x) * (DW+CW)'(c);
    end
endmodule

module fir_prog #(
    parameter int                 DW        = 8,
    parameter int                 CW        = 8,
    parameter int                 TAPS      = 4,
    parameter int                 OW        = 16,
    parameter logic [TAPS*CW-1:0] COEF_INIT = {8'd34, 8'd94, 8'd94, 8'd34}
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [DW-1:0]           in,
    input  logic                    clear,
    input  logic                    coef_we,
    input  logic [$clog2(TAPS)-1:0] coef_addr,
    input  logic [CW-1:0]           coef_data,
    output logic                    out_valid,
    output logic [OW-1:0]           out,
    output logic                    sat
);
    localparam int AW = $clog2(TAPS);
    localparam int PW = DW + CW;
    // 32 taps add at most 5 bits of growth; one extra bit keeps the clamp
    // compare valid even when OW is wider than the real sum.
    localparam int SW = PW + 6;
    localparam logic [SW-1:0] MAXV   = (SW'(1) << OW) - SW'(1);
    localparam logic [AW:0]   TAPS_W = (AW+1)'(TAPS);

    logic [TAPS-1:0][CW-1:0] coef;
    logic [TAPS-1:0][DW-1:0] taps;
    logic [TAPS-1:0][PW-1:0] prod;
    logic [2:0]              vld_pipe;   // [0]=accept, [1]=taps valid, [2]=products valid

    // Coefficient writes land one edge late. Products are taken one edge
    // after acceptance, so a deferred write keeps a sample accepted on the
    // write edge on the old coefficients while the next sample sees the new.
    logic          wr_pend;
    logic [AW-1:0] wr_addr;
    logic [CW-1:0] wr_data;

    assign vld_pipe[0] = in_valid & ~clear;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_pend <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
            coef    <= COEF_INIT;
        end else begin
            wr_pend <= coef_we & ({1'b0, coef_addr} < TAPS_W);
            wr_addr <= coef_addr;
            wr_data <= coef_data;
            if (wr_pend) coef[wr_addr] <= wr_data;
        end
    end

    // Delay line: shifts only on accept edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)              taps <= '0;
        else if (clear)       taps <= '0;
        else if (vld_pipe[0]) taps <= {taps[TAPS-2:0], in};
    end

    generate
        for (genvar k = 0; k < TAPS; k++) begin : g_tap
            fir_prog_tap #(.DW(DW), .CW(CW)) u_tap (
                .clk (clk),
                .rst (rst),
                .en  (vld_pipe[1]),
                .x   (taps[k]),
                .c   (coef[k]),
                .p   (prod[k])
            );
        end
    endgenerate

    logic [SW-1:0] sum;
    logic          sat_n;

    always_comb begin
        sum = '0;
        for (int k = 0; k < TAPS; k++) sum = sum + SW'(prod[k]);
        sat_n = (sum > MAXV);
    end

    // Clear kills every in-flight stage, including the one about to emit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe[2:1] <= '0;
            out_valid     <= 1'b0;
            out           <= '0;
            sat           <= 1'b0;
        end else begin
            vld_pipe[1] <= vld_pipe[0];
            vld_pipe[2] <= vld_pipe[1] & ~clear;
            out_valid   <= vld_pipe[2] & ~clear;
            if (vld_pipe[2] & ~clear) begin
                out <= sat_n ? {OW{1'b1}} : sum[OW-1:0];
                sat <= sat_n;
            end
        end
    end
endmodule

// File: doc/fir_prog.md
FIR_PROG -- requirements
Module: fir_prog

Interface
REQ-001 SHALL provide parameter DW, default 8, input sample width (unsigned).
REQ-002 SHALL provide parameter CW, default 8, coefficient width (unsigned).
REQ-003 SHALL provide parameter TAPS, default 4, number of taps, legal range 2..32.
REQ-004 SHALL provide parameter OW, default 16, output width; legal range DW+CW-1..DW+CW+5.
REQ-005 SHALL provide parameter COEF_INIT, default {8'd34,8'd94,8'd94,8'd34} packed TAPS*CW bits, tap 0 in the least significant CW bits.
REQ-006 clk  input  1  single clock, all state on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 in_valid  input  1  sample strobe; sample accepted on any edge where in_valid=1 and clear=0.
REQ-009 in  input  DW  input sample.
REQ-010 clear  input  1  synchronous flush of delay line and pipeline.
REQ-011 coef_we  input  1  coefficient write enable.
REQ-012 coef_addr  input  clog2(TAPS)  coefficient index.
REQ-013 coef_data  input  CW  coefficient value.
REQ-014 out_valid  output  1  one-cycle pulse per accepted sample.
REQ-015 out  output  OW  filtered result.
REQ-016 sat  output  1  high with out_valid when the result was clamped.

Function
REQ-017 SHALL compute y[n] = sum over k=0..TAPS-1 of c[k]*x[n-k], unsigned, full-precision products (DW+CW bits) and full-precision accumulation.
REQ-018 SHALL clamp results exceeding 2^OW-1 to 2^OW-1 and assert sat; else sat=0.
REQ-019 Delay line SHALL shift only on accept edges: tap0<=in, tap k<=tap k-1; idle cycles hold contents.
REQ-020 Pipeline: stage 1 SHALL register all TAPS products on the edge after acceptance; stage 2 SHALL register the saturated sum on the following edge.
REQ-021 out, sat and out_valid SHALL update on the 2nd rising edge after the accept edge; out_valid high for exactly one cycle per accepted sample.
REQ-022 Back-to-back in_valid SHALL yield back-to-back out_valid, throughput one sample per clock.
REQ-023 out and sat SHALL hold their last value while out_valid=0.
REQ-024 coef_we=1 SHALL write coef_data to c[coef_addr] on that edge; coef_addr>=TAPS SHALL be ignored.
REQ-025 A sample accepted on the same edge as a coefficient write SHALL use old coefficients; the next accepted sample SHALL use the new one.
REQ-026 clear=1 SHALL zero the delay line and cancel all in-flight samples (no out_valid from them); in_valid on the same edge SHALL be discarded; coefficients, out and sat SHALL be unaffected.
REQ-027 Coefficient write and clear on the same edge SHALL both take effect.

Reset
REQ-028 rst=1 SHALL asynchronously zero delay line, product registers, out, sat and out_valid, and load c[k] from COEF_INIT.
REQ-029 rst asserted mid-operation SHALL discard all in-flight samples; first out_valid after release SHALL come 2 edges after the first accepted sample.
REQ-030 Coefficient writes while rst=1 SHALL be ignored.

Verification
REQ-031 Defaults, impulse in=1 then 0,0,0 on consecutive cycles -> out_valid 4 consecutive cycles, out=34,94,94,34, sat=0, first result 2 edges after impulse accept.
REQ-032 Defaults, in=255 held 6 cycles -> steady out=65280, sat=0.
REQ-033 Write c[0..3]=255, in=255 held -> steady out=65535, sat=1.
REQ-034 Impulse with in_valid gaps (1,idle,0,idle,0,idle,0) -> out 34,94,94,34 only on valid pulses; out holds during gaps.
REQ-035 Write c[1]=10 on same edge as sample x=1, then samples 0,0 -> outputs 34, 10, 94 (first uses old c[0], later samples new c[1]).
REQ-036 clear one cycle after accepting in=1 -> no out_valid for that sample; next impulse -> 34,94,94,34; repeat with rst pulse instead -> same, and coefficients return to COEF_INIT.
